impulse_receiver: RTL
=====================

# impulse_receiver

Synchronous receiving end of the impulse link: it takes an asynchronous impulse line `x`, as driven by the rising-edge impulse generators, and recovers its events. Each impulse is synchronized and its width is measured in clock cycles. If the width is legal, the block toggles a level output and hands the width to a consumer over a four-phase `dav_`/`rfd` handshake. The block sits between any impulse source and clocked logic that needs events as levels or data.

## Interface
- `MIN_W`, default 2: minimum legal impulse width, in cycles (≥1).
- `MAX_W`, default 8: maximum legal impulse width, in cycles (≥`MIN_W`, < 2^`CNT_W`−1).
- `CNT_W`, default 4: width counter and `width` bus size.
- `clock`  in  1: single clock, rising edge.
- `reset_`  in  1: asynchronous, active-low reset.
- `x`  in  1: asynchronous impulse input.
- `rfd`  in  1: consumer ready-for-data (handshake acknowledge).
- `z`  out  1: level output, toggled once per accepted impulse.
- `width`  out  `CNT_W`: measured width of the last accepted impulse.
- `dav_`  out  1: data available, active-low.
- `err`  out  1: one-cycle pulse when an impulse is rejected for width.
- `ovr`  out  1: sticky flag, set when an impulse arrives during a handshake.

## Operation
- Synchronization:
  - `x` passes through two flops, giving `s`; `sp` is `s` delayed by one cycle.
  - A rising edge means `s=1 & sp=0`; a falling edge means `s=0 & sp=1`.
- Arming after reset: an `armed` flag is 0 at reset and is set the first cycle `s=0`. Edges are ignored while unarmed, so a pulse already high at reset release is discarded.
- States:
  - IDLE: on a rising edge (armed), go to MEAS with `cnt=1`.
  - MEAS: while `s=1`, `cnt` increments, saturating at `MAX_W+1`. On a falling edge, evaluate `cnt`:
    - `MIN_W ≤ cnt ≤ MAX_W`: toggle `z`, load `width=cnt`, drive `dav_=0`, go to ACK.
    - Otherwise: pulse `err`, go to IDLE; `z` and `width` are unchanged.
  - ACK: hold `dav_=0` and `width` until `rfd` is sampled 0, then set `dav_=1` and go to REL.
  - REL: when `rfd` is sampled 1, go to IDLE.
- Rising edges seen in ACK or REL are dropped, not measured, and set `ovr=1`. `ovr` clears only on reset.
- `err` and a drop never occur together: a drop happens only outside MEAS.
- Reset mid-operation clears everything immediately; any impulse in flight is lost.
- Reset values: `z=0`, `width=0`, `dav_=1`, `err=0`, `ovr=0`, state IDLE, `cnt=0`, sync flops 0, `armed=0`.

## Timing
- A clock-aligned impulse of N cycles yields `cnt=N`. Asynchronous impulses may measure ±1.
- Latency: the first cycle `x` is sampled 0 after the impulse is cycle F. Then `s` is 0 at F+1 (the falling edge is seen in MEAS), and `z`, `width` and `dav_=0` are visible after the clock edge ending F+1.
- `err` asserts in the same cycle slot `dav_` would have fallen, for exactly one cycle.
- Handshake:
  - Minimum ACK duration is 1 cycle after `dav_` falls.
  - `rfd` is sampled every cycle, with no internal synchronizer; the consumer must be on `clock`.
  - `width` is stable from `dav_` falling until `dav_` rises.
- Back-to-back: a new impulse is measured only if its synchronized rising edge occurs in IDLE. The consumer must finish REL before the next impulse arrives.
- `x` must be low at least 1 cycle between impulses. A shorter gap is not guaranteed to be separated.

## Configuration
- `IMPULSE_RECEIVER_TIMEOUT_EN` defined:
  - When `cnt` would exceed `MAX_W` during MEAS, `err` pulses immediately.
  - The FSM then enters a LOW state and waits for `s=0` before returning to IDLE.
  - The error is reported at cycle MAX_W+1 of the impulse instead of at its fall.
- Not defined: no LOW state. An over-long impulse is reported only at its falling edge, with `cnt` saturated at `MAX_W+1`.

## Test plan
- Reset: hold `reset_=0` with `x=1`, release, keep `x=1` for 5 cycles, then drop it. Required: no `dav_`, no `err`, `z=0`.
- Legal impulse (defaults): `x` high 4 cycles with `rfd=1`. Required: `z` goes 0→1, `width=4`, `dav_=0` two cycles after `x` falls. Then drive `rfd=0`, then 1. Required: `dav_` rises, `z` stays 1, state IDLE.
- Width bounds: impulses of 1, 2, 8 and 9 cycles, each with a full handshake. Required: `err` for 1 and 9; accepts with `width=2` and `width=8`; `z` toggles exactly twice.
- Overrun: accept a 3-cycle impulse, keep `rfd=1` (no ack), send a 5-cycle impulse. Required: `ovr=1`, `width` stays 3, and no second `dav_` after completing the handshake.
- Timeout: a 12-cycle impulse. With the macro, `err` pulses at cycle 9 of the impulse. Without it, `err` pulses 2 cycles after `x` falls.
- Async reset mid-MEAS: assert `reset_` for 1 cycle during a 6-cycle impulse. Required: all outputs go to their reset values immediately, and no `dav_` or `err` follows for that impulse.

Source files
------------

// File: rtl/impulse_receiver.sv
// Impulse link receiver: synchronizes x, measures each impulse width and hands it over dav_/rfd.
// Optional macro IMPULSE_RECEIVER_TIMEOUT_EN reports over-long impulses at MAX_W+1 cycles.
module impulse_receiver #(
    parameter int unsigned MIN_W = 2,
    parameter int unsigned MAX_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             x,
    input  logic             rfd,
    output logic             z,
    output logic [CNT_W-1:0] width,
    output logic             dav_,
    output logic             err,
    output logic             ovr
);

    localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StMeas, StAck, StRel, StLow} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1, s, sp;
    logic [1:0]       fill;
    logic             armed;
    logic             rise;

    // The reset zeros in the sync chain are not samples of x, so arming waits until s is real.
    assign rise = armed & s & ~sp;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= StIdle;
            cnt   <= '0;
            sync1 <= 1'b0;
            s     <= 1'b0;
            sp    <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            z     <= 1'b0;
            width <= '0;
            dav_  <= 1'b1;
            err   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            sync1 <= x;
            s     <= sync1;
            sp    <= s;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && !s) armed <= 1'b1;
            err <= 1'b0;
            case (state)
                StIdle: begin
                    if (rise) begin
                        state <= StMeas;
                        cnt   <= OneCnt;
                    end
                end
                StMeas: begin
                    if (s) begin
`ifdef IMPULSE_RECEIVER_TIMEOUT_EN
                        if (cnt >= MaxCnt) begin
                            err   <= 1'b1;
                            state <= StLow;
                        end else begin
                            cnt <= cnt + OneCnt;
                        end
`else
                        if (cnt <= MaxCnt) cnt <= cnt + OneCnt;
`endif
                    end else if (cnt >= MinCnt && cnt <= MaxCnt) begin
                        z     <= ~z;
                        width <= cnt;
                        dav_  <= 1'b0;
                        state <= StAck;
                    end else begin
                        err   <= 1'b1;
                        state <= StIdle;
                    end
                end
                StAck: begin
                    if (rise) ovr <= 1'b1;
                    if (!rfd) begin
                        dav_  <= 1'b1;
                        state <= StRel;
                    end
                end
                StRel: begin
                    if (rise) ovr <= 1'b1;
                    if (rfd) state <= StIdle;
                end
                StLow: begin
                    if (!s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
